// File: rtl/conv_pkg.sv
// Shared types and helpers for the row-bank sweep scheduler.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        SWEEP,
        RELEASE,
        FIN
    } sched_state_e;

    localparam int RD_LAT     = 1;
    localparam int KW_DEFAULT = 3;

    // Modular add for bank indices; callers guarantee idx < 2*nm, so no divider is needed.
    function automatic int bank_wrap(input int idx, input int nm);
        return (idx >= nm) ? idx - nm : idx;
    endfunction

endpackage

// File: rtl/line_buf_sched_if.sv
// Handshake bundle between line_buf_sched, the bank memory unit and column assembly.
interface line_buf_sched_if
    import conv_pkg::*;
#(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int NM = 4,
    parameter int KW = KW_DEFAULT,
    parameter int BW = $clog2(NM)
);
    logic [XB-1:0]    cfg_width;
    logic [YB-1:0]    cfg_height;
    logic             start;
    logic [NM-1:0]    mb_full;
    logic             col_ready;
    logic [NM-1:0]    mem_used;
    logic [XB-1:0]    rd_addr;
    logic             rd_en;
    logic [KW*BW-1:0] row_bank;
    logic             col_valid;
    logic             col_last_x;
    logic             col_last_y;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [15:0]      perf_stall_cnt;

    modport slave (
        input  cfg_width, cfg_height, start, mb_full, col_ready,
        output mem_used, rd_addr, rd_en, row_bank, col_valid, col_last_x, col_last_y,
               busy, done, cfg_err, perf_stall_cnt
    );

    modport master (
        output cfg_width, cfg_height, start, mb_full, col_ready,
        input  mem_used, rd_addr, rd_en, row_bank, col_valid, col_last_x, col_last_y,
               busy, done, cfg_err, perf_stall_cnt
    );

endinterface

// File: rtl/sched_ring_ptr.sv
// Oldest-bank pointer over NM row banks; emits the KW-bank window and its fill status.
module sched_ring_ptr
    import conv_pkg::*;
#(
    parameter int NM = 4,
    parameter int KW = KW_DEFAULT,
    parameter int BW = $clog2(NM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic [NM-1:0]    i_mb_full,
    output logic [BW-1:0]    o_top_bank,
    output logic [KW*BW-1:0] o_row_bank,
    output logic             o_win_full
);

    logic [BW-1:0] r_top_bank;
    logic [BW-1:0] w_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top_bank <= '0;
        end else if (i_advance) begin
            r_top_bank <= BW'(bank_wrap(int'(r_top_bank) + 1, NM));
        end
    end

    always_comb begin
        o_row_bank = '0;
        o_win_full = 1'b1;
        w_idx      = '0;
        for (int k = 0; k < KW; k++) begin
            w_idx                  = BW'(bank_wrap(int'(r_top_bank) + k, NM));
            o_row_bank[k*BW +: BW] = w_idx;
            o_win_full             = o_win_full & i_mb_full[w_idx];
        end
    end

    assign o_top_bank = r_top_bank;

endmodule

// File: rtl/line_buf_sched.sv
// Row-bank sweep scheduler: waits for KW full banks, sweeps columns, releases the oldest bank.
// Optional stall counter built only with LINE_BUF_SCHED_PERF_EN defined.
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_FILL | waiting for the KW window banks to hold complete rows
//   SWEEP     | issuing column reads while col_ready
//   RELEASE   | free oldest bank, advance window
//   FIN       | one-cycle done pulse
module line_buf_sched
    import conv_pkg::*;
#(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int NM = 4,
    parameter int KW = KW_DEFAULT,
    parameter int BW = $clog2(NM)
) (
    input  logic             clk,
    input  logic             rst,
    line_buf_sched_if.slave  bus
);

    sched_state_e     r_state;
    logic [XB-1:0]    r_width;
    logic [YB-1:0]    r_height;
    logic [XB-1:0]    r_col;
    logic [YB-1:0]    r_out_row;
    logic             r_rd_en;
    logic [XB-1:0]    r_rd_addr;
    logic [NM-1:0]    r_mem_used;
    logic             r_done;
    logic             r_cfg_err;
    logic [KW*BW-1:0] r_row_bank;
    logic [RD_LAT-1:0] r_vld_sr;
    logic [RD_LAT-1:0] r_lx_sr;
    logic [RD_LAT-1:0] r_ly_sr;

    logic [BW-1:0]    w_top_bank;
    logic [KW*BW-1:0] w_row_bank;
    logic             w_win_full;
    logic [YB-1:0]    w_last_row;

    assign w_last_row = r_height - YB'(KW);

    sched_ring_ptr #(.NM(NM), .KW(KW), .BW(BW)) u_ring (
        .clk        (clk),
        .rst        (rst),
        .i_advance  (r_state == RELEASE),
        .i_mb_full  (bus.mb_full),
        .o_top_bank (w_top_bank),
        .o_row_bank (w_row_bank),
        .o_win_full (w_win_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_width    <= '0;
            r_height   <= '0;
            r_col      <= '0;
            r_out_row  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_mem_used <= '0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            for (int k = 0; k < KW; k++) r_row_bank[k*BW +: BW] <= BW'(k);
        end else begin
            r_rd_en    <= 1'b0;
            r_mem_used <= '0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_width  <= bus.cfg_width;
                        r_height <= bus.cfg_height;
                        if (bus.cfg_width == '0 || bus.cfg_height < YB'(KW)) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= FIN;
                        end else begin
                            r_cfg_err <= 1'b0;
                            r_out_row <= '0;
                            r_state   <= WAIT_FILL;
                        end
                    end
                end
                WAIT_FILL: begin
                    // Window ordering is frozen here so it covers the sweep and its read latency.
                    if (w_win_full) begin
                        r_col      <= '0;
                        r_row_bank <= w_row_bank;
                        r_state    <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (bus.col_ready) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_col;
                        r_col     <= r_col + XB'(1);
                        if (r_col == r_width - XB'(1)) r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_mem_used <= NM'(1) << w_top_bank;
                    r_out_row  <= r_out_row + YB'(1);
                    r_state    <= (r_out_row == w_last_row) ? FIN : WAIT_FILL;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_sr <= '0;
            r_lx_sr  <= '0;
            r_ly_sr  <= '0;
        end else begin
            r_vld_sr[0] <= r_rd_en;
            r_lx_sr[0]  <= r_rd_en && (r_rd_addr == r_width - XB'(1));
            r_ly_sr[0]  <= r_rd_en && (r_out_row == w_last_row);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
                r_lx_sr[i]  <= r_lx_sr[i-1];
                r_ly_sr[i]  <= r_ly_sr[i-1];
            end
        end
    end

`ifdef LINE_BUF_SCHED_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_perf <= '0;
        end else if ((r_state == WAIT_FILL || (r_state == SWEEP && !bus.col_ready))
                     && r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign bus.perf_stall_cnt = r_perf;
`else
    assign bus.perf_stall_cnt = '0;
`endif

    assign bus.mem_used   = r_mem_used;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.rd_en      = r_rd_en;
    assign bus.row_bank   = r_row_bank;
    assign bus.col_valid  = r_vld_sr[RD_LAT-1];
    assign bus.col_last_x = r_lx_sr[RD_LAT-1];
    assign bus.col_last_y = r_ly_sr[RD_LAT-1];
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed bench for line_buf_sched: frame sweeps, fill stall, backpressure, bad config, reset, busy start.
module tb_line_buf_sched;

    localparam int XB = 10;
    localparam int YB = 10;
    localparam int NM = 4;
    localparam int KW = 3;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    line_buf_sched_if #(.XB(XB), .YB(YB), .NM(NM), .KW(KW), .BW(BW)) bus ();

    line_buf_sched #(.XB(XB), .YB(YB), .NM(NM), .KW(KW), .BW(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int               q_addr[$];
    logic [KW*BW-1:0] q_rb[$];
    logic [NM-1:0]    q_mu[$];
    logic             q_lx[$];
    logic             q_ly[$];
    int               n_done = 0;
    int               n_lag_bad = 0;
    int               t_first_rd = -1;
    int               t_done = -1;
    int               t_mu_last = -1;
    logic             prev_rd_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_rd_en = 1'b0;
        end else begin
            if (bus.col_valid !== prev_rd_en) n_lag_bad++;
            if (bus.rd_en) begin
                if (t_first_rd < 0) t_first_rd = cyc;
                q_addr.push_back(int'(bus.rd_addr));
                q_rb.push_back(bus.row_bank);
            end
            if (bus.col_valid) begin
                q_lx.push_back(bus.col_last_x);
                q_ly.push_back(bus.col_last_y);
            end
            if (bus.mem_used != '0) begin
                q_mu.push_back(bus.mem_used);
                t_mu_last = cyc;
            end
            if (bus.done) begin
                n_done++;
                t_done = cyc;
            end
            prev_rd_en = bus.rd_en;
        end
    end

    function automatic logic [KW*BW-1:0] exp_rb(input int top);
        logic [KW*BW-1:0] v;
        v = '0;
        for (int k = 0; k < KW; k++) v[k*BW +: BW] = BW'((top + k) % NM);
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_rb.delete();
        q_mu.delete();
        q_lx.delete();
        q_ly.delete();
        n_done = 0;
        n_lag_bad = 0;
        t_first_rd = -1;
        t_done = -1;
        t_mu_last = -1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.mb_full = '0;
        bus.col_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clear_log();
    endtask

    task automatic pulse_start(input int w, input int h);
        bus.cfg_width = XB'(w);
        bus.cfg_height = YB'(h);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.rd_en, bus.col_valid, bus.col_last_x, bus.col_last_y, bus.done, bus.busy, bus.cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000", {bus.rd_en, bus.col_valid, bus.col_last_x, bus.col_last_y, bus.done, bus.busy, bus.cfg_err});
        end
        checks++;
        if (bus.mem_used !== 4'h0) begin errors++; $display("FAIL reset_mem_used: got %h want 0", bus.mem_used); end
        checks++;
        if (bus.rd_addr !== 10'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
        checks++;
        if (bus.row_bank !== 6'h24) begin errors++; $display("FAIL reset_row_bank: got %h want 24", bus.row_bank); end
        checks++;
        if (bus.perf_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_perf: got %0d want 0", bus.perf_stall_cnt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        bus.mb_full = 4'hF;
        bus.col_ready = 1'b1;
        pulse_start(8, 5);
        for (int i = 0; i < 200 && n_done < 1; i++) tick();
        tick();
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
        checks++;
        if (q_addr.size() !== 24) begin errors++; $display("FAIL basic_rd_count: got %0d want 24", q_addr.size()); end
        for (int i = 0; i < 24 && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== i % 8) begin errors++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, q_addr[i], i % 8); end
            checks++;
            if (q_rb[i] !== exp_rb(i / 8)) begin errors++; $display("FAIL basic_row_bank[%0d]: got %h want %h", i, q_rb[i], exp_rb(i / 8)); end
        end
        checks++;
        if (q_mu.size() !== 3) begin errors++; $display("FAIL basic_release_count: got %0d want 3", q_mu.size()); end
        for (int i = 0; i < 3 && i < q_mu.size(); i++) begin
            checks++;
            if (q_mu[i] !== 4'(1 << i)) begin errors++; $display("FAIL basic_mem_used[%0d]: got %b want %b", i, q_mu[i], 4'(1 << i)); end
        end
        checks++;
        if (q_lx.size() !== 24) begin errors++; $display("FAIL basic_valid_count: got %0d want 24", q_lx.size()); end
        for (int i = 0; i < 24 && i < q_lx.size(); i++) begin
            checks++;
            if (q_lx[i] !== (i % 8 == 7)) begin errors++; $display("FAIL basic_last_x[%0d]: got %b want %b", i, q_lx[i], (i % 8 == 7)); end
            checks++;
            if (q_ly[i] !== (i >= 16)) begin errors++; $display("FAIL basic_last_y[%0d]: got %b want %b", i, q_ly[i], (i >= 16)); end
        end
        checks++;
        if (t_done !== t_mu_last + 1) begin errors++; $display("FAIL basic_done_after_release: got cycle %0d want %0d", t_done, t_mu_last + 1); end
        checks++;
        if (n_lag_bad !== 0) begin errors++; $display("FAIL basic_valid_lag: got %0d bad cycles want 0", n_lag_bad); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_fill_stall();
        int c0;
        do_reset();
        bus.mb_full = 4'b0011;
        bus.col_ready = 1'b1;
        pulse_start(8, 5);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (q_addr.size() !== 0) begin errors++; $display("FAIL stall_no_read: got %0d reads want 0", q_addr.size()); end
`ifdef LINE_BUF_SCHED_PERF_EN
        checks++;
        if (bus.perf_stall_cnt < 16'd20) begin errors++; $display("FAIL stall_perf: got %0d want >=20", bus.perf_stall_cnt); end
`else
        checks++;
        if (bus.perf_stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_perf_off: got %0d want 0", bus.perf_stall_cnt); end
`endif
        c0 = cyc;
        bus.mb_full = 4'b0111;
        for (int i = 0; i < 20 && t_first_rd < 0; i++) tick();
        checks++;
        if (t_first_rd !== c0 + 2) begin errors++; $display("FAIL stall_first_rd: got cycle %0d want %0d", t_first_rd, c0 + 2); end
        bus.mb_full = 4'hF;
        for (int i = 0; i < 200 && n_done < 1; i++) tick();
        checks++;
        if (q_addr.size() !== 24 || n_done !== 1) begin
            errors++;
            $display("FAIL stall_frame_end: got reads=%0d done=%0d want reads=24 done=1", q_addr.size(), n_done);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.mb_full = 4'hF;
        bus.col_ready = 1'b1;
        pulse_start(4, 3);
        for (int i = 0; i < 100 && n_done < 1; i++) begin
            bus.col_ready = ~bus.col_ready;
            tick();
        end
        bus.col_ready = 1'b1;
        tick();
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", n_done); end
        checks++;
        if (q_addr.size() !== 4) begin errors++; $display("FAIL bp_rd_count: got %0d want 4", q_addr.size()); end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== i) begin errors++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, q_addr[i], i); end
        end
        for (int i = 0; i < 4 && i < q_lx.size(); i++) begin
            checks++;
            if (q_lx[i] !== (i == 3)) begin errors++; $display("FAIL bp_last_x[%0d]: got %b want %b", i, q_lx[i], (i == 3)); end
            checks++;
            if (q_ly[i] !== 1'b1) begin errors++; $display("FAIL bp_last_y[%0d]: got %b want 1", i, q_ly[i]); end
        end
        checks++;
        if (n_lag_bad !== 0) begin errors++; $display("FAIL bp_valid_lag: got %0d bad cycles want 0", n_lag_bad); end
        checks++;
        if (q_mu.size() !== 1 || (q_mu.size() == 1 && q_mu[0] !== 4'b0001)) begin
            errors++;
            $display("FAIL bp_release: got %0d pulses want one 0001", q_mu.size());
        end
    endtask

    task automatic test_bad_config();
        int cs;
        do_reset();
        bus.mb_full = 4'hF;
        bus.col_ready = 1'b1;
        cs = cyc;
        pulse_start(8, 2);
        for (int i = 0; i < 10 && n_done < 1; i++) tick();
        checks++;
        if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL bad_h_cfg_err: got %b want 1", bus.cfg_err); end
        checks++;
        if (t_done !== cs + 2) begin errors++; $display("FAIL bad_h_done_time: got cycle %0d want %0d", t_done, cs + 2); end
        checks++;
        if (q_addr.size() !== 0 || q_mu.size() !== 0) begin
            errors++;
            $display("FAIL bad_h_activity: got reads=%0d releases=%0d want 0 0", q_addr.size(), q_mu.size());
        end
        tick();
        clear_log();
        pulse_start(4, 3);
        for (int i = 0; i < 100 && n_done < 1; i++) tick();
        checks++;
        if (bus.cfg_err !== 1'b0 || q_addr.size() !== 4) begin
            errors++;
            $display("FAIL good_after_bad: got cfg_err=%b reads=%0d want 0 4", bus.cfg_err, q_addr.size());
        end
        tick();
        clear_log();
        pulse_start(0, 5);
        for (int i = 0; i < 10 && n_done < 1; i++) tick();
        checks++;
        if (bus.cfg_err !== 1'b1 || n_done !== 1 || q_addr.size() !== 0) begin
            errors++;
            $display("FAIL bad_w_zero: got cfg_err=%b done=%0d reads=%0d want 1 1 0", bus.cfg_err, n_done, q_addr.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.mb_full = 4'hF;
        bus.col_ready = 1'b1;
        pulse_start(8, 5);
        for (int i = 0; i < 200 && q_addr.size() < 12; i++) tick();
        checks++;
        if (q_addr.size() !== 12 || (q_addr.size() == 12 && q_addr[11] !== 3)) begin
            errors++;
            $display("FAIL ar_reach_col3: got reads=%0d want 12 ending at column 3", q_addr.size());
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.rd_en, bus.col_valid, bus.busy, bus.done} !== 4'b0 || bus.mem_used !== 4'h0 || bus.rd_addr !== 10'd0) begin
            errors++;
            $display("FAIL ar_outputs: got en/vld/busy/done=%b mem_used=%h rd_addr=%0d want 0", {bus.rd_en, bus.col_valid, bus.busy, bus.done}, bus.mem_used, bus.rd_addr);
        end
        checks++;
        if (bus.row_bank !== 6'h24) begin errors++; $display("FAIL ar_row_bank: got %h want 24", bus.row_bank); end
        tick();
        tick();
        checks++;
        if (q_mu.size() !== 1) begin errors++; $display("FAIL ar_no_extra_release: got %0d pulses want 1", q_mu.size()); end
        rst = 1'b1;
        clear_log();
        tick();
        pulse_start(8, 5);
        for (int i = 0; i < 200 && n_done < 1; i++) tick();
        checks++;
        if (n_done !== 1 || q_addr.size() !== 24) begin
            errors++;
            $display("FAIL ar_replay_counts: got done=%0d reads=%0d want 1 24", n_done, q_addr.size());
        end
        for (int i = 0; i < 3 && i < q_mu.size(); i++) begin
            checks++;
            if (q_mu[i] !== 4'(1 << i)) begin errors++; $display("FAIL ar_replay_mem_used[%0d]: got %b want %b", i, q_mu[i], 4'(1 << i)); end
        end
        for (int s = 0; s < 3 && s * 8 < q_rb.size(); s++) begin
            checks++;
            if (q_rb[s*8] !== exp_rb(s)) begin errors++; $display("FAIL ar_replay_row_bank[%0d]: got %h want %h", s, q_rb[s*8], exp_rb(s)); end
        end
    endtask

    task automatic test_start_busy();
        do_reset();
        bus.mb_full = 4'hF;
        bus.col_ready = 1'b1;
        pulse_start(8, 5);
        for (int i = 0; i < 100 && q_addr.size() < 3; i++) tick();
        pulse_start(2, 3);
        for (int i = 0; i < 300 && n_done < 1; i++) tick();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (q_mu.size() !== 3) begin errors++; $display("FAIL busy_release_count: got %0d want 3", q_mu.size()); end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
        checks++;
        if (q_addr.size() !== 24 || (q_addr.size() == 24 && q_addr[23] !== 7)) begin
            errors++;
            $display("FAIL busy_reads: got %0d reads want 24 ending at 7", q_addr.size());
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got %b want 0", bus.busy); end
    endtask

    initial begin
        bus.cfg_width = '0;
        bus.cfg_height = '0;
        bus.start = 1'b0;
        bus.mb_full = '0;
        bus.col_ready = 1'b0;
        test_reset();
        test_basic();
        test_fill_stall();
        test_backpressure();
        test_bad_config();
        test_async_reset();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/line_buf_sched.md
Name: line_buf_sched

Overview:
- Sequencer for the row-buffer memory banks that feed the column/pixel datapath.
- Waits until KW consecutive banks hold complete rows, then sweeps a shared column read address across them.
- Presents the bank ordering for the vertical window and releases the oldest bank so the input side can refill it.
- Sits between the bank memory unit (mb_full/mem_used/read address) and the column-assembly logic.

Parameters:
- XB, 10, column counter/address width
- YB, 10, row counter width
- NM, 4, number of row banks; must be >= KW+1
- KW, 3, window height in rows (banks read per sweep)
- BW, $clog2(NM), bank index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_width  in  XB  columns per row; latched on start
- cfg_height  in  YB  rows per frame; latched on start
- start  in  1  one-cycle frame start
- mb_full  in  NM  bank holds a complete row
- col_ready  in  1  downstream can accept one column RD_LAT cycles later
- mem_used  out  NM  one-cycle release pulse per bank
- rd_addr  out  XB  column address shared by all banks
- rd_en  out  1  read issued this cycle
- row_bank  out  KW*BW  bank index of window row k at bits [k*BW +: BW]; row 0 is the oldest
- col_valid  out  1  column data valid (rd_en delayed RD_LAT)
- col_last_x  out  1  with col_valid: last column of row
- col_last_y  out  1  with col_valid: last output row
- busy  out  1  state != IDLE
- done  out  1  one-cycle frame-complete pulse
- cfg_err  out  1  sticky: illegal config at start
- perf_stall_cnt  out  16  stall counter (see optional feature)

Behaviour:
- Reset (rst=0, async) clears all state and outputs:
  - state=IDLE, top_bank=0, col=0, out_row=0
  - mem_used, rd_en, col_valid, col_last_x, col_last_y, done, cfg_err, busy = 0
  - rd_addr=0; row_bank={2,1,0} for defaults
- Reset mid-frame abandons the frame; no release pulses are emitted.
- FSM states: IDLE, WAIT_FILL, SWEEP, RELEASE, FIN.
  - IDLE: start=1 latches cfg. If width<1 or height<KW: cfg_err<=1 and go to FIN. Otherwise cfg_err<=0, out_row=0, go to WAIT_FILL.
  - WAIT_FILL: leave when mb_full is set for banks top_bank..top_bank+KW-1 (mod NM); col<=0, go to SWEEP.
  - SWEEP: when col_ready=1, rd_en=1, rd_addr=col, col++. When col_ready=0, no issue and col holds. Issuing col==width-1 goes to RELEASE.
  - RELEASE (1 cycle): mem_used[top_bank]=1; top_bank<=(top_bank+1) mod NM; out_row++. Go to FIN if out_row==height-KW (last output row), else WAIT_FILL.
  - FIN (1 cycle): done=1, go to IDLE.
- start is ignored while busy.
- RD_LAT=1:
  - col_valid(t+1)=rd_en(t)
  - col_last_x(t+1)=(rd_addr==width-1)
  - col_last_y(t+1)=(out_row==height-KW)
  - row_bank is stable for the whole sweep plus RD_LAT.
- Output rows per frame = height-KW+1; columns per row = width.
- Bank wrap: top_bank is modulo NM arithmetic, including non-power-of-2 NM.
- Only the oldest bank is released per row; the remaining KW-1 banks are reused for the next window.
- If mb_full drops for a window bank during SWEEP, the sweep is not affected (the memory unit's responsibility).

Optional Feature:
- Macro: LINE_BUF_SCHED_PERF_EN.
- Defined: perf_stall_cnt increments, saturating at 16'hFFFF, on every cycle with (state==WAIT_FILL) or (state==SWEEP && !col_ready). It clears on accepted start.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package conv_pkg holds:
  - sched_state_e enum (IDLE, WAIT_FILL, SWEEP, RELEASE, FIN)
  - localparam RD_LAT=1
  - localparam KW default
  - function bank_wrap(idx, NM) for modular add
- Natural sub-module: sched_ring_ptr.
  - Modular top_bank counter with advance input.
  - Produces the KW-wide row_bank vector and the "KW banks full" check from mb_full.

Test Plan:
- Basic frame: width=8, height=5, mb_full=4'hF held, col_ready=1.
  - 3 sweeps of 8 rd_en each, rd_addr 0..7.
  - mem_used pulses 0001, 0010, 0100.
  - row_bank per sweep {2,1,0}, {3,2,1}, {0,3,2}.
  - done after the 3rd release; col_last_y only on the 3rd sweep.
- Fill stall: mb_full=4'b0011 for 20 cycles, then 4'b0111.
  - No rd_en before 4'b0111.
  - First rd_en 2 cycles after mb_full reaches 4'b0111.
  - perf_stall_cnt >= 20 with LINE_BUF_SCHED_PERF_EN.
- Backpressure: width=4, col_ready toggling 1,0,1,0.
  - rd_addr sequence 0,1,2,3 with no duplicates or skips.
  - col_valid lags rd_en by exactly 1 cycle.
  - col_last_x only with column 3.
- Bad config: start with height=2.
  - cfg_err=1, done pulse 2 cycles after start.
  - No rd_en and no mem_used.
- Async reset mid-SWEEP: rst=0 at column 3 of row 1.
  - All outputs 0 immediately; state IDLE.
  - A new start with width=8, height=5 replays the basic-frame response from top_bank=0.
- start while busy: a second start during SWEEP is ignored; frame completes with exactly 3 releases and 1 done.
